// File: rtl/wb2byteio_port.sv
// Wishbone-to-byte GPIO port: pin read (A), output data (S), direction (C/CC) registers.
// Optional macro WB2BYTEIO_INSYNC_EN adds a two-flop synchronizer on the pin-read path.
module wb2byteio_port #(
    parameter int ASIZE = 2,
    parameter int DSIZE = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [ASIZE-1:0] i_adr,
    input  logic             i_stb,
    input  logic             i_we,
    input  logic [DSIZE-1:0] i_dat,
    output logic             o_ack,
    output logic [DSIZE-1:0] o_dat,
    inout  wire  [DSIZE-1:0] o_iobuf
);

    typedef enum logic {
        WB_IDLE,
        WB_ACK
    } wb_state_e;

    wb_state_e        r_state;
    wb_state_e        w_state_next;
    logic             w_commit;
    logic [DSIZE-1:0] r_s;
    logic [DSIZE-1:0] r_c;
    logic [DSIZE-1:0] r_dat;
    logic [DSIZE-1:0] w_pins;
    logic [DSIZE-1:0] w_rdata;
    logic             w_sel_a;
    logic             w_sel_s;
    logic             w_sel_c;

    // Direction bit 1 releases the pin so the external driver owns it.
    for (genvar g = 0; g < DSIZE; g++) begin : g_pin
        assign o_iobuf[g] = r_c[g] ? 1'bz : r_s[g];
    end

`ifdef WB2BYTEIO_INSYNC_EN
    logic [DSIZE-1:0] r_sync1;
    logic [DSIZE-1:0] r_sync2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= o_iobuf;
            r_sync2 <= r_sync1;
        end
    end

    assign w_pins = r_sync2;
`else
    assign w_pins = o_iobuf;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= WB_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_commit     = 1'b0;
        o_ack        = 1'b0;
        unique case (r_state)
            WB_IDLE: begin
                if (i_stb) begin
                    w_state_next = WB_ACK;
                    w_commit     = 1'b1;
                end
            end
            WB_ACK: begin
                o_ack        = 1'b1;
                w_state_next = WB_IDLE;
            end
            default: w_state_next = WB_IDLE;
        endcase
    end

    // Address 3 is a full alias of C.
    always_comb begin
        w_sel_a = (i_adr == ASIZE'(0));
        w_sel_s = (i_adr == ASIZE'(1));
        w_sel_c = (i_adr == ASIZE'(2)) || (i_adr == ASIZE'(3));
        w_rdata = '0;
        if (w_sel_a) begin
            w_rdata = w_pins;
        end else if (w_sel_s) begin
            w_rdata = r_s;
        end else if (w_sel_c) begin
            w_rdata = r_c;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s   <= '0;
            r_c   <= '0;
            r_dat <= '0;
        end else if (w_commit) begin
            if (i_we) begin
                if (w_sel_s) r_s <= i_dat;
                if (w_sel_c) r_c <= i_dat;
            end else begin
                r_dat <= w_rdata;
            end
        end
    end

    assign o_dat = r_dat;

endmodule

// File: tb/tb_wb2byteio_port.sv
// Randomized self-checking bench for wb2byteio_port against a register/pin-level model.
module tb_wb2byteio_port;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] adr = '0;
    logic       stb = 1'b0;
    logic       we = 1'b0;
    logic [7:0] dat = '0;
    logic       ack;
    logic [7:0] rdat;
    wire  [7:0] io;
    logic [7:0] ext_en = '0;
    logic [7:0] ext_val = '0;

    int n_checks = 0;
    int n_fail = 0;

    // Model state: output register, direction register, last read data.
    logic [7:0] m_s = '0;
    logic [7:0] m_c = '0;
    logic [7:0] m_rd = '0;

    for (genvar g = 0; g < 8; g++) begin : g_ext
        assign io[g] = ext_en[g] ? ext_val[g] : 1'bz;
    end

    always #5 clk = ~clk;

    wb2byteio_port #(
        .ASIZE(2),
        .DSIZE(8)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_adr  (adr),
        .i_stb  (stb),
        .i_we   (we),
        .i_dat  (dat),
        .o_ack  (ack),
        .o_dat  (rdat),
        .o_iobuf(io)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_pins();
        return (m_s & ~m_c) | (ext_val & m_c);
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One transaction with stb held for two cycles; ack expected only in the second.
    task automatic xfer(input logic w, input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        stb = 1'b1;
        we  = w;
        adr = a;
        dat = d;
        check_eq("ack_cycle1", {31'd0, ack}, 32'd0);
        if (!w) begin
            case (a)
                2'd0:    m_rd = model_pins();
                2'd1:    m_rd = m_s;
                default: m_rd = m_c;
            endcase
        end else if (a == 2'd1) begin
            m_s = d;
        end else if (a != 2'd0) begin
            m_c = d;
        end
        @(negedge clk);
        check_eq("ack_cycle2", {31'd0, ack}, 32'd1);
        check_eq("rdat", {24'd0, rdat}, {24'd0, m_rd});
        ext_en = m_c;
        @(negedge clk);
        stb = 1'b0;
        check_eq("ack_cycle3", {31'd0, ack}, 32'd0);
        check_eq("pins", {24'd0, io}, {24'd0, model_pins()});
    endtask

    initial begin
        #2;
        check_eq("ack_in_reset", {31'd0, ack}, 32'd0);
        check_eq("rdat_in_reset", {24'd0, rdat}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("ack_after_reset", {31'd0, ack}, 32'd0);
        check_eq("pins_after_reset", {24'd0, io}, 32'd0);
        xfer(1'b0, 2'd1, 8'h00);
        check_eq("s_after_reset", {24'd0, rdat}, 32'd0);
        xfer(1'b0, 2'd2, 8'h00);
        check_eq("c_after_reset", {24'd0, rdat}, 32'd0);

        // Write S and see it on the pins with all bits outputs.
        xfer(1'b1, 2'd1, 8'hA5);
        check_eq("pins_a5", {24'd0, io}, 32'h0000_00A5);
        xfer(1'b0, 2'd1, 8'h00);
        check_eq("s_a5", {24'd0, rdat}, 32'h0000_00A5);

        // All inputs: both C aliases read FF, bus follows the external driver only.
        xfer(1'b1, 2'd2, 8'hFF);
        xfer(1'b0, 2'd2, 8'h00);
        check_eq("c_adr2", {24'd0, rdat}, 32'h0000_00FF);
        xfer(1'b0, 2'd3, 8'h00);
        check_eq("c_adr3", {24'd0, rdat}, 32'h0000_00FF);
        ext_val = 8'h3C;
        idle(3);
        check_eq("bus_released", {24'd0, io}, 32'h0000_003C);
        xfer(1'b0, 2'd0, 8'h00);
        check_eq("in_3c", {24'd0, rdat}, 32'h0000_003C);
        ext_val = 8'hC3;
        idle(3);
        xfer(1'b0, 2'd0, 8'h00);
        check_eq("in_c3", {24'd0, rdat}, 32'h0000_00C3);

        // Mixed direction: upper nibble input, lower nibble output.
        xfer(1'b1, 2'd3, 8'hF0);
        xfer(1'b1, 2'd1, 8'h5A);
        ext_val = 8'h96;
        idle(3);
        xfer(1'b0, 2'd0, 8'h00);
        check_eq("mixed_a", {24'd0, rdat}, 32'h0000_009A);
        xfer(1'b0, 2'd1, 8'h00);
        check_eq("mixed_s", {24'd0, rdat}, 32'h0000_005A);

        // Writes to A are ignored and leave o_dat untouched.
        xfer(1'b1, 2'd0, 8'h77);
        check_eq("hold_rdat", {24'd0, rdat}, 32'h0000_005A);
        xfer(1'b0, 2'd1, 8'h00);
        check_eq("a_wr_s", {24'd0, rdat}, 32'h0000_005A);
        xfer(1'b0, 2'd2, 8'h00);
        check_eq("a_wr_c", {24'd0, rdat}, 32'h0000_00F0);

        for (int i = 0; i < 40; i++) begin
            ext_val = 8'($urandom);
            idle(3);
            xfer(1'($urandom), 2'($urandom), 8'($urandom));
        end

        // Reset while in the ACK state.
        @(negedge clk);
        stb = 1'b1;
        we  = 1'b1;
        adr = 2'd1;
        dat = 8'hE7;
        @(negedge clk);
        check_eq("ack_before_rst", {31'd0, ack}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("ack_drop_rst", {31'd0, ack}, 32'd0);
        check_eq("rdat_drop_rst", {24'd0, rdat}, 32'd0);
        m_s  = '0;
        m_c  = '0;
        m_rd = '0;
        ext_en = '0;
        @(negedge clk);
        stb = 1'b0;
        we  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("pins_post_rst", {24'd0, io}, 32'd0);
        check_eq("ack_post_rst", {31'd0, ack}, 32'd0);
        xfer(1'b0, 2'd1, 8'h00);
        check_eq("s_post_rst", {24'd0, rdat}, 32'd0);
        xfer(1'b0, 2'd3, 8'h00);
        check_eq("c_post_rst", {24'd0, rdat}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb2byteio_port.md
WB2BYTEIO_PORT -- requirements
Module: wb2byteio

Interface
REQ-001 SHALL have parameter ASIZE, default 2, Wishbone address width.
REQ-002 SHALL have parameter DSIZE, default 8, data and IO port width.
REQ-003 SHALL have port i_clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1 bit, reset, asynchronous and active-low.
REQ-005 SHALL have port i_adr, input, ASIZE bits, register select.
REQ-006 SHALL have port i_stb, input, 1 bit, Wishbone strobe (request).
REQ-007 SHALL have port i_we, input, 1 bit, write enable (1 = write, 0 = read).
REQ-008 SHALL have port i_dat, input, DSIZE bits, write data.
REQ-009 SHALL have port o_ack, output, 1 bit, Wishbone acknowledge.
REQ-010 SHALL have port o_dat, output, DSIZE bits, read data.
REQ-011 SHALL have port o_iobuf, inout, DSIZE bits, bidirectional pin bus.

Function
REQ-012 SHALL decode the register map as:
- 0 (A): pin read; writes ignored.
- 1 (S): output data register, read/write.
- 2 (C): direction register, read/write; bit = 1 input, bit = 0 output.
- 3 (CC): full alias of C for both read and write.
REQ-013 SHALL drive o_iobuf[i] with S[i] when C[i] = 0, and SHALL tri-state it (Z) when C[i] = 1, independently per bit.
REQ-014 SHALL implement a two-state handshake FSM with states WB_IDLE and WB_ACK.
REQ-015 SHALL transition from WB_IDLE to WB_ACK at the rising edge where i_stb = 1 is sampled; otherwise remain in WB_IDLE.
REQ-016 SHALL transition from WB_ACK to WB_IDLE unconditionally on the next edge, whatever the value of i_stb.
REQ-017 SHALL drive o_ack = 1 exactly while the state is WB_ACK: one cycle per request, one cycle after the strobe is sampled.
REQ-018 SHALL commit a write to S or C at the IDLE-to-ACK edge, using i_adr, i_we and i_dat sampled at that edge.
REQ-019 SHALL register o_dat at the IDLE-to-ACK edge for a read (i_we = 0):
- A returns the current o_iobuf pin values (S value on output bits, external value on input bits).
- S returns S; C and CC return C.
REQ-020 SHALL hold o_dat unchanged on writes and while idle, until the next read.
REQ-021 SHALL not re-trigger while i_stb stays high into the ACK-to-IDLE edge; the master deasserts i_stb after ack, and a strobe still high in the following IDLE cycle starts a new transaction.
REQ-022 SHALL let a new direction take effect on the pins in the cycle after the write commits.

Reset
REQ-023 SHALL, while i_rst_n = 0, asynchronously force state = WB_IDLE, o_ack = 0, S = 0, C = 0 and o_dat = 0, so all pins drive 0 out of reset.
REQ-024 SHALL abort an in-flight transaction if reset is asserted mid-operation, with no write committed after the reset edge.

Configuration
REQ-025 SHALL support macro WB2BYTEIO_INSYNC_EN:
- Defined: pin values read via address A pass through a two-flop synchronizer clocked by i_clk and reset to 0, adding 2 cycles of latency.
- Undefined: the A read samples o_iobuf directly at the IDLE-to-ACK edge.

Verification
REQ-026 SHALL check reset: after i_rst_n rises, state = WB_IDLE, C = 00, S = 00, o_ack = 0, o_iobuf = 00.
REQ-027 SHALL check write timing: write S = A5 with stb held 2 cycles -> o_ack high exactly in the 2nd cycle, S = A5, o_iobuf = A5 with C = 00.
REQ-028 SHALL check read-back: write C = FF, then read address 2 and address 3 -> o_dat = FF both times and o_iobuf fully Z.
REQ-029 SHALL check the input path (macro undefined): C = FF, external drive 3C, read A -> o_dat = 3C; change drive to C3, read A -> o_dat = C3.
REQ-030 SHALL check mixed direction: C = F0, S = 5A, external drive of the high nibble = 9 -> read A returns 9A, read S returns 5A.
REQ-031 SHALL check edge cases: write to address 0 -> S and C unchanged; reset asserted while state = WB_ACK -> o_ack drops immediately and registers read 00.
